// File: rtl/i2c_pkg.sv
// Shared FSM encoding and quarter-phase names for the I2C transfer scheduler.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } state_t;

  localparam logic [1:0] Q_LOW_A  = 2'd0;
  localparam logic [1:0] Q_LOW_B  = 2'd1;
  localparam logic [1:0] Q_HIGH_A = 2'd2;
  localparam logic [1:0] Q_HIGH_B = 2'd3;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 32'sd1) % n;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module i2c_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [IDXW-1:0] win_idx,
  output logic            any
);

  logic [IDXW-1:0] cand_s;
  logic [IDXW-1:0] idx_s;

  // Scan from the farthest slot back to ptr so the nearest requester is written last.
  always_comb begin
    idx_s  = ptr;
    cand_s = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = IDXW'((int'(ptr) + k) % NREQ);
      idx_s  = req[cand_s] ? cand_s : idx_s;
    end
  end

  assign any     = |req;
  assign win_idx = idx_s;
  assign win     = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_s) : {NREQ{1'b0}};

endmodule

// File: rtl/i2c_xfer_scheduler.sv
// Arbitrates NREQ requesters onto one I2C master and sequences single-byte
// transfers, advancing only on the SCL generator's quarter ticks.
module i2c_xfer_scheduler #(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              ack_err,
  output logic              busy,
  input  logic              qtick,
  input  logic [1:0]        qphase,
  output logic              scl_ena,
  output logic              sda_oe,
  input  logic              sda_i
);
  import i2c_pkg::*;

  state_t          state_r, state_s;
  logic [NREQ-1:0] grant_r, grant_s, done_r, done_s;
  logic [IDXW-1:0] owner_r, owner_s, ptr_r, ptr_s;
  logic [6:0]      addr_r, addr_s;
  logic            rw_r, rw_s, err_r, err_s;
  logic [7:0]      wdata_r, wdata_s, shift_r, shift_s, rdata_r, rdata_s;
  logic [2:0]      bitcnt_r, bitcnt_s;
  logic            ack_err_r, ack_err_s, busy_r, busy_s;
  logic            scl_ena_r, scl_ena_s, sda_oe_r, sda_oe_s;
  logic [NREQ-1:0] arb_win_s;
  logic [IDXW-1:0] arb_idx_s;
  logic            arb_any_s;
  logic            reading_s;

  i2c_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr_r),
    .win     (arb_win_s),
    .win_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  assign reading_s = (state_r == DATA) && rw_r;

  // Next-state and datapath updates; nothing moves without a quarter tick except the done pulse.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    addr_s    = addr_r;
    rw_s      = rw_r;
    wdata_s   = wdata_r;
    shift_s   = shift_r;
    bitcnt_s  = bitcnt_r;
    err_s     = err_r;
    rdata_s   = rdata_r;
    ack_err_s = ack_err_r;
    busy_s    = busy_r;
    scl_ena_s = scl_ena_r;
    sda_oe_s  = sda_oe_r;
    ptr_s     = ptr_r;
    done_s    = {NREQ{1'b0}};
    if (qtick) begin
      case (state_r)
        IDLE: begin
          if ((qphase == Q_HIGH_A) && arb_any_s) begin
            owner_s  = arb_idx_s;
            grant_s  = arb_win_s;
            addr_s   = req_addr[int'(arb_idx_s)*7 +: 7];
            rw_s     = req_rw[arb_idx_s];
            wdata_s  = req_wdata[int'(arb_idx_s)*8 +: 8];
            err_s    = 1'b0;
            busy_s   = 1'b1;
            sda_oe_s = 1'b1;
            state_s  = START;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (qphase == Q_LOW_A) begin
            scl_ena_s = 1'b1;
            shift_s   = {addr_r, rw_r};
            bitcnt_s  = 3'd7;
            state_s   = ADDR;
          end else begin
            state_s = START;
          end
        end
        ADDR, DATA: begin
          case (qphase)
            Q_LOW_B:  sda_oe_s = reading_s ? 1'b0 : ~shift_r[7];
            Q_HIGH_A: shift_s  = reading_s ? {shift_r[6:0], sda_i} : shift_r;
            Q_HIGH_B: begin
              shift_s  = reading_s ? shift_r : {shift_r[6:0], 1'b0};
              bitcnt_s = (bitcnt_r == 3'd0) ? bitcnt_r : bitcnt_r - 3'd1;
              if (bitcnt_r == 3'd0) begin
                state_s = (state_r == ADDR) ? ADDR_ACK : DATA_ACK;
              end else begin
                state_s = state_r;
              end
            end
            default: shift_s = shift_r;
          endcase
        end
        ADDR_ACK: begin
          case (qphase)
            Q_LOW_B:  sda_oe_s = 1'b0;
            Q_HIGH_A: err_s    = err_r | sda_i;
            Q_HIGH_B: begin
              // A NACKed address skips the data byte entirely.
              state_s  = err_r ? STOP : DATA;
              shift_s  = err_r ? shift_r : wdata_r;
              bitcnt_s = 3'd7;
            end
            default: err_s = err_r;
          endcase
        end
        DATA_ACK: begin
          case (qphase)
            Q_LOW_B:  sda_oe_s = 1'b0;
            Q_HIGH_A: err_s    = rw_r ? err_r : (err_r | sda_i);
            Q_HIGH_B: begin
              rdata_s = rw_r ? shift_r : rdata_r;
              state_s = STOP;
            end
            default: err_s = err_r;
          endcase
        end
        STOP: begin
          case (qphase)
            Q_LOW_B:  sda_oe_s  = 1'b1;
            Q_HIGH_A: scl_ena_s = 1'b0;
            Q_HIGH_B: begin
              sda_oe_s  = 1'b0;
              done_s    = grant_r;
              ack_err_s = err_r;
              grant_s   = {NREQ{1'b0}};
              busy_s    = 1'b0;
              ptr_s     = IDXW'(rr_next(int'(owner_r), NREQ));
              state_s   = IDLE;
            end
            default: sda_oe_s = sda_oe_r;
          endcase
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // All state and outputs are registered; rst drops straight to idle without a STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= {NREQ{1'b0}};
      done_r    <= {NREQ{1'b0}};
      owner_r   <= {IDXW{1'b0}};
      ptr_r     <= {IDXW{1'b0}};
      addr_r    <= 7'd0;
      rw_r      <= 1'b0;
      wdata_r   <= 8'd0;
      shift_r   <= 8'd0;
      bitcnt_r  <= 3'd0;
      err_r     <= 1'b0;
      rdata_r   <= 8'd0;
      ack_err_r <= 1'b0;
      busy_r    <= 1'b0;
      scl_ena_r <= 1'b0;
      sda_oe_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      addr_r    <= addr_s;
      rw_r      <= rw_s;
      wdata_r   <= wdata_s;
      shift_r   <= shift_s;
      bitcnt_r  <= bitcnt_s;
      err_r     <= err_s;
      rdata_r   <= rdata_s;
      ack_err_r <= ack_err_s;
      busy_r    <= busy_s;
      scl_ena_r <= scl_ena_s;
      sda_oe_r  <= sda_oe_s;
    end
  end

  assign grant   = grant_r;
  assign done    = done_r;
  assign rdata   = rdata_r;
  assign ack_err = ack_err_r;
  assign busy    = busy_r;
  assign scl_ena = scl_ena_r;
  assign sda_oe  = sda_oe_r;

endmodule

// File: tb/tb_i2c_xfer_scheduler.sv
// Bench for i2c_xfer_scheduler: quarter-tick generator, open-drain bus monitor,
// behavioural slave and a round-robin/transfer reference model.
module tb_i2c_xfer_scheduler;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   grant, done;
  logic [7:0]        rdata;
  logic              ack_err, busy, qtick, scl_ena, sda_oe, sda_i;
  logic [1:0]        qphase;
  logic              slave_pull;

  i2c_xfer_scheduler #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata),
    .ack_err(ack_err), .busy(busy), .qtick(qtick), .qphase(qphase),
    .scl_ena(scl_ena), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  // Wired-AND open-drain line: low if either master or slave pulls.
  assign sda_i = ~(sda_oe | slave_pull);

  int checks = 0, failures = 0, xfers_done = 0;
  logic [6:0] t_addr [NREQ];
  logic       t_rw   [NREQ];
  logic [7:0] t_wdata[NREQ];
  logic [1:0] ph = 2'd0;
  int   ptr_m = 0, owner_m = -1, n_start = 0, n_stop = 0;
  logic [7:0] exp_rdata = 8'd0;
  bit   s_addr_ack, s_data_ack, rand_slave, hold_all, stretch_arm, rst_arm;
  logic [7:0] s_rbyte;
  bit   prev_scl = 1'b1, prev_sda = 1'b1;
  bit   bits[$];
  logic [NREQ-1:0] grant_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({grant, done, rdata, ack_err, busy, scl_ena, sda_oe});
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = {v[30:0], logic'(q[i])};
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // What the slave pulls for the n-th bit of the frame (0-based).
  function automatic bit slave_bit(input int n);
    bit rd;
    rd = (n > 7) ? bits[7] : 1'b0;
    if (n == 8) return s_addr_ack;
    if (n >= 9 && n <= 16) return rd && s_addr_ack && !s_rbyte[16 - n];
    if (n == 17) return !rd && s_addr_ack && s_data_ack;
    return 1'b0;
  endfunction

  task automatic set_req(input int r, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    t_addr[r] = a; t_rw[r] = rw; t_wdata[r] = wd;
    req_addr[7*r +: 7] = a; req_rw[r] = rw; req_wdata[8*r +: 8] = wd; req[r] = 1'b1;
  endtask

  task automatic handle_done();
    bit eb[$];
    logic [7:0] db;
    logic rw;
    if (owner_m < 0) begin
      check_eq("done_spurious", 32'(done), 32'd0);
      return;
    end
    rw = t_rw[owner_m];
    check_eq("done_owner", 32'(done), 32'(1 << owner_m));
    check_eq("grant_clear", 32'(grant), 32'd0);
    check_eq("busy_clear", 32'(busy), 32'd0);
    check_eq("stop_seen", n_stop, n_start);
    for (int i = 6; i >= 0; i--) eb.push_back(t_addr[owner_m][i]);
    eb.push_back(rw);
    eb.push_back(!s_addr_ack);
    if (s_addr_ack) begin
      db = rw ? s_rbyte : t_wdata[owner_m];
      for (int i = 7; i >= 0; i--) eb.push_back(db[i]);
      eb.push_back(rw ? 1'b1 : !s_data_ack);
    end
    // SCL is released just before STOP, seen as one more rising edge with SDA low.
    eb.push_back(1'b0);
    check_eq("bit_count", bits.size(), eb.size());
    check_eq("bit_seq", pack(bits), pack(eb));
    check_eq("ack_err", 32'(ack_err), 32'(!s_addr_ack || (!rw && !s_data_ack)));
    if (s_addr_ack && rw) exp_rdata = s_rbyte;
    check_eq("rdata", 32'(rdata), 32'(exp_rdata));
    ptr_m = (owner_m + 1) % NREQ;
    if (!hold_all) req[owner_m] = 1'b0;
    owner_m = -1;
    xfers_done++;
  endtask

  task automatic monitor_step();
    bit scl, sda;
    scl = scl_ena ? ph[1] : 1'b1;
    sda = ~(sda_oe | slave_pull);
    if (prev_scl && scl && prev_sda && !sda) begin
      n_start++;
      bits.delete();
      if (rand_slave) begin
        s_addr_ack = ($urandom_range(3, 0) != 0);
        s_data_ack = ($urandom_range(3, 0) != 0);
        s_rbyte    = 8'($urandom);
      end
    end else if (prev_scl && scl && !prev_sda && sda) begin
      n_stop++;
    end else if (!prev_scl && scl) begin
      bits.push_back(sda);
    end
    prev_scl = scl;
    prev_sda = sda;
    if (!scl) slave_pull = slave_bit(bits.size());
    if (done != '0) begin
      handle_done();
    end else if (owner_m >= 0) begin
      check_eq("grant_held", 32'(grant), 32'(1 << owner_m));
    end else if (grant != '0) begin
      owner_m = rr_pick(req, ptr_m);
      check_eq("grant_pick", 32'(grant), 32'(1 << owner_m));
      check_eq("busy_set", 32'(busy), 32'd1);
      grant_log.push_back(grant);
    end
  endtask

  task automatic do_stretch();
    logic [31:0] snap;
    bit moved = 1'b0;
    stretch_arm = 1'b0;
    snap = outs();
    repeat (50) begin
      qphase = 2'($urandom);
      @(posedge clk); #1;
      if (outs() != snap) moved = 1'b1;
    end
    qphase = ph;
    check_eq("stretch_frozen", 32'(moved), 32'd0);
  endtask

  task automatic do_reset();
    rst_arm = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midxfer_reset", outs(), 32'd0);
    ptr_m = 0; owner_m = -1; exp_rdata = 8'd0;
    n_start = 0; n_stop = 0; bits.delete();
    slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
  endtask

  task automatic quarter();
    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
    qtick = 1'b1;
    qphase = ph;
    @(posedge clk); #1;
    qtick = 1'b0;
    monitor_step();
    ph = ph + 2'd1;
    if (stretch_arm && bits.size() == 12) do_stretch();
    if (rst_arm && bits.size() == 12) do_reset();
  endtask

  task automatic run_until(input int target, input int budget);
    int q = 0;
    while (xfers_done < target && q < budget) begin
      quarter();
      q++;
    end
    check_eq("xfer_complete", xfers_done, target);
  endtask

  initial begin
    rst = 1'b1; qtick = 1'b0; qphase = 2'd0; slave_pull = 1'b0;
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    rand_slave = 1'b0; hold_all = 1'b0; stretch_arm = 1'b0; rst_arm = 1'b0;
    s_addr_ack = 1'b1; s_data_ack = 1'b1; s_rbyte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_outputs", outs(), 32'd0);

    set_req(0, 7'h50, 1'b0, 8'hA5);
    run_until(xfers_done + 1, 300);

    s_rbyte = 8'h96;
    set_req(1, 7'h3C, 1'b1, 8'h00);
    run_until(xfers_done + 1, 300);

    s_addr_ack = 1'b0;
    set_req(2, 7'h2A, 1'b1, 8'h00);
    run_until(xfers_done + 1, 300);

    // Two requesters held high continuously must alternate.
    s_addr_ack = 1'b1;
    hold_all = 1'b1;
    set_req(0, 7'h12, 1'b0, 8'h34);
    set_req(1, 7'h56, 1'b0, 8'h78);
    run_until(xfers_done + 4, 500);
    req = '0;
    hold_all = 1'b0;
    for (int k = grant_log.size() - 3; k < grant_log.size(); k++)
      check_eq("rr_alternate", 32'(grant_log[k] ^ grant_log[k-1]), 32'd3);

    stretch_arm = 1'b1;
    set_req(1, 7'h11, 1'b0, 8'hC3);
    run_until(xfers_done + 1, 300);

    rst_arm = 1'b1;
    s_rbyte = 8'h5B;
    set_req(0, 7'h22, 1'b1, 8'h00);
    run_until(xfers_done + 1, 400);

    rand_slave = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NREQ; r++)
        if (!req[r] && $urandom_range(1, 0) == 1)
          set_req(r, 7'($urandom), 1'($urandom), 8'($urandom));
      if (req == '0) set_req(int'($urandom_range(NREQ - 1, 0)), 7'($urandom), 1'($urandom), 8'($urandom));
      run_until(xfers_done + 1, 400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
